// File: rtl/axi_mem_slave_p.sv
// axi_mem_slave_p
//   AXI memory slave. The write and read channels are handled by two
//   independent FSMs that share one word-addressed memory array.
//   Bursts can be FIXED, INCR or WRAP. Byte strobes are supported.
//   The slave honours backpressure on both the B and R channels.
//   Every beat is a full DATA_W-wide word; narrow transfers are not supported.
//
// Parameters
//   ID_W    width of the id fields
//   ADDR_W  byte address width
//   DATA_W  data width (32 or 64)
//   DEPTH   number of memory words
//
// Ports
//   aclk, arst                   clock; synchronous active-high reset
//   aw* / w* / b*                write address, write data, write response
//   ar* / r*                     read address, read data
//
// Optional feature
//   Macro AXI_SLV_RANGE_CHECK_EN enables an address range check.
//   When the macro is defined, a beat whose byte address is at or above
//   DEPTH*DATA_W/8 is not stored on writes and reads back as zero.
//   Such a beat is answered with DECERR.
//   When the macro is undefined, the word index simply wraps modulo DEPTH.
module axi_mem_slave_p #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                  aclk,
  input  logic                  arst,
  input  logic [ID_W-1:0]       awid,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic [7:0]            awlen,
  input  logic [1:0]            awburst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [ID_W-1:0]       bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ID_W-1:0]       arid,
  input  logic [ADDR_W-1:0]     araddr,
  input  logic [7:0]            arlen,
  input  logic [1:0]            arburst,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ID_W-1:0]       rid,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] B_FIXED = 2'b00;
  localparam logic [1:0] B_INCR  = 2'b01;
  localparam logic [1:0] B_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

`ifdef AXI_SLV_RANGE_CHECK_EN
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH * BYTES);
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  // Storage. Contents survive reset on purpose.
  logic [DATA_W-1:0] mem [DEPTH];

  // ---------------------------------------------------------------- helpers
  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(BYTES - 1);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a >> OFF_W) % ADDR_W'(DEPTH));
  endfunction

  // Two cases are flagged as bad bursts:
  //   - the reserved burst encoding
  //   - a WRAP burst whose length is not 2, 4, 8 or 16 beats
  // A bad burst still runs, but as INCR, and every beat of it reports SLVERR.
  function automatic logic bad_burst(input logic [1:0] b, input logic [7:0] len);
    return (b == 2'b11) ||
           ((b == B_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

  function automatic logic [1:0] eff_burst(input logic [1:0] b, input logic [7:0] len);
    return bad_burst(b, len) ? B_INCR : b;
  endfunction

  // WRAP: the wrap window is (len+1) beats long. Once the incremented address
  // crosses a window boundary, it returns to the bottom of the window.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [1:0]        b,
                                                  input logic [7:0]        len);
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] n;
    inc  = a + ADDR_W'(BYTES);
    mask = ((ADDR_W'(len) + ADDR_W'(1)) << OFF_W) - ADDR_W'(1);
    case (b)
      B_FIXED: n = a;
      B_WRAP:  n = ((inc & mask) == '0) ? (a & ~mask) : inc;
      default: n = inc;
    endcase
    return n;
  endfunction

  // ---------------------------------------------------------------- write FSM
  wstate_t           wstate_q, wstate_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wlen_q, wlen_d;
  logic [1:0]        wburst_q, wburst_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic              wslv_q, wslv_d;   // sticky SLVERR for this burst
  logic              wdec_q, wdec_d;   // sticky DECERR for this burst
  logic              wr_oor;
  logic              mem_we;
  logic              w_last_beat;

  always_comb begin
    wstate_d    = wstate_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    waddr_d     = waddr_q;
    wlen_d      = wlen_q;
    wburst_d    = wburst_q;
    wcnt_d      = wcnt_q;
    wslv_d      = wslv_q;
    wdec_d      = wdec_q;
    mem_we      = 1'b0;
    w_last_beat = (wcnt_q == wlen_q);
`ifdef AXI_SLV_RANGE_CHECK_EN
    wr_oor = ({1'b0, waddr_q} >= LIMIT);
`else
    wr_oor = 1'b0;
`endif
    case (wstate_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (awvalid && awready_q) begin
          bid_d     = awid;
          waddr_d   = align(awaddr);
          wlen_d    = awlen;
          wburst_d  = eff_burst(awburst, awlen);
          wslv_d    = bad_burst(awburst, awlen);
          wdec_d    = 1'b0;
          wcnt_d    = 8'd0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          wstate_d  = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid && wready_q) begin
          mem_we  = !wr_oor && !arst;
          wcnt_d  = wcnt_q + 8'd1;
          waddr_d = next_addr(waddr_q, wburst_q, wlen_q);
          // A misplaced wlast only flags an error; the beat count decides
          // when the burst ends.
          wslv_d  = wslv_q | (wlast != w_last_beat);
          wdec_d  = wdec_q | wr_oor;
          if (w_last_beat) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = wdec_d ? RESP_DECERR : (wslv_d ? RESP_SLVERR : RESP_OKAY);
            wstate_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bvalid_q && bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wburst_q  <= B_FIXED;
      wcnt_q    <= '0;
      wslv_q    <= 1'b0;
      wdec_q    <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wburst_q  <= wburst_d;
      wcnt_q    <= wcnt_d;
      wslv_q    <= wslv_d;
      wdec_q    <= wdec_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb[b]) mem[word_idx(waddr_q)][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- read FSM
  rstate_t           rstate_q, rstate_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rlast_q, rlast_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;   // address of the next beat to present
  logic [7:0]        rlen_q, rlen_d;
  logic [1:0]        rburst_q, rburst_d;
  logic [7:0]        rcnt_q, rcnt_d;     // index of the next beat to present
  logic              rslv_q, rslv_d;
  logic              load;
  logic              ld_last;
  logic              ld_slv;
  logic              ld_oor;
  logic [ADDR_W-1:0] ld_addr;
  logic [1:0]        ar_eff;

  // The memory is read combinationally and the result is registered into rdata.
  // As a result, a read and a write to the same word in the same cycle return
  // the word's old contents.
  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rburst_d  = rburst_q;
    rcnt_d    = rcnt_q;
    rslv_d    = rslv_q;
    load      = 1'b0;
    ld_last   = 1'b0;
    ld_slv    = rslv_q;
    ld_addr   = raddr_q;
    ar_eff    = eff_burst(arburst, arlen);
    case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arvalid && arready_q) begin
          ld_addr   = align(araddr);
          ld_slv    = bad_burst(arburst, arlen);
          ld_last   = (arlen == 8'd0);
          load      = 1'b1;
          rid_d     = arid;
          rlen_d    = arlen;
          rburst_d  = ar_eff;
          rslv_d    = ld_slv;
          rcnt_d    = 8'd1;
          raddr_d   = next_addr(align(araddr), ar_eff, arlen);
          arready_d = 1'b0;
          rstate_d  = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && rready) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            rstate_d  = R_IDLE;
          end else begin
            load    = 1'b1;
            ld_last = (rcnt_q == rlen_q);
            rcnt_d  = rcnt_q + 8'd1;
            raddr_d = next_addr(raddr_q, rburst_q, rlen_q);
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
`ifdef AXI_SLV_RANGE_CHECK_EN
    ld_oor = ({1'b0, ld_addr} >= LIMIT);
`else
    ld_oor = 1'b0;
`endif
    if (load) begin
      rvalid_d = 1'b1;
      rlast_d  = ld_last;
      rdata_d  = ld_oor ? '0 : mem[word_idx(ld_addr)];
      rresp_d  = ld_oor ? RESP_DECERR : (ld_slv ? RESP_SLVERR : RESP_OKAY);
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rburst_q  <= B_FIXED;
      rcnt_q    <= '0;
      rslv_q    <= 1'b0;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rburst_q  <= rburst_d;
      rcnt_q    <= rcnt_d;
      rslv_q    <= rslv_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;

endmodule

// File: tb/tb_axi_mem_slave_p.sv
// Directed bench for axi_mem_slave_p with its default parameters
// (DATA_W=32, DEPTH=1024).
module tb_axi_mem_slave_p;

  logic        aclk = 1'b0;
  logic        arst;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  axi_mem_slave_p dut (
    .aclk(aclk), .arst(arst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  logic [31:0] wd [16];
  logic [31:0] rd [16];
  logic [1:0]  rr [16];
  logic        rl [16];
  logic [3:0]  rid_s;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one write burst. The beat with index last_at carries wlast.
  // After bvalid rises, bready is held low for bhold cycles.
  task automatic axi_write(input string tag, input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst,
                           input logic [3:0] strb, input int last_at, input int bhold,
                           input logic [1:0] exp_resp);
    int n;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 20) begin @(posedge aclk); #1; n++; end
    chk({tag, "_aw_hs"}, 64'(n < 20), 64'd1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wd[i]; wstrb = strb; wlast = (i == last_at); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 20) begin @(posedge aclk); #1; n++; end
      chk($sformatf("%s_w%0d_hs", tag, i), 64'(n < 20), 64'd1);
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk({tag, "_bvalid"}, 64'(bvalid), 64'd1);
    for (int k = 0; k < bhold; k++) begin
      @(posedge aclk); #1;
      chk($sformatf("%s_bhold%0d_bvalid", tag, k), 64'(bvalid), 64'd1);
      chk($sformatf("%s_bhold%0d_awready", tag, k), 64'(awready), 64'd0);
    end
    chk({tag, "_bresp"}, 64'(bresp), 64'(exp_resp));
    chk({tag, "_bid"}, 64'(bid), 64'(id));
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    chk({tag, "_b_done"}, 64'(bvalid), 64'd0);
    chk({tag, "_awready_back"}, 64'(awready), 64'd1);
  endtask

  // Run one read burst and collect the beats into rd/rr/rl.
  // rready is dropped for stall_n cycles when the beat with index stall_at appears.
  task automatic axi_read(input string tag, input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [1:0] burst,
                          input int stall_at, input int stall_n);
    int n;
    int nb;
    int cyc;
    logic [31:0] sd;
    logic [3:0]  sid;
    logic [1:0]  sr;
    logic        sl;
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(posedge aclk); #1; n++; end
    chk({tag, "_ar_hs"}, 64'(n < 20), 64'd1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    chk({tag, "_first_lat"}, 64'(rvalid), 64'd1);
    nb = 0; cyc = 0;
    while (nb <= int'(len) && cyc < 100) begin
      if (rvalid) begin
        if (nb == stall_at && stall_n > 0) begin
          rready = 1'b0;
          sd = rdata; sid = rid; sr = rresp; sl = rlast;
          for (int k = 0; k < stall_n; k++) begin
            @(posedge aclk); #1;
            chk($sformatf("%s_stall%0d", tag, k),
                {rvalid, rlast, rresp, rid, rdata}, {1'b1, sl, sr, sid, sd});
          end
          rready = 1'b1;
        end
        rd[nb] = rdata; rr[nb] = rresp; rl[nb] = rlast; rid_s = rid;
        nb++;
      end
      @(posedge aclk); #1;
      cyc++;
    end
    rready = 1'b0;
    chk({tag, "_nbeats"}, 64'(nb), 64'(int'(len) + 1));
    chk({tag, "_cycles"}, 64'(cyc), 64'(int'(len) + 1));
    chk({tag, "_rvalid_end"}, 64'(rvalid), 64'd0);
    chk({tag, "_arready_back"}, 64'(arready), 64'd1);
    chk({tag, "_rid"}, 64'(rid_s), 64'(id));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_w [4];
    arst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;

    // Power-up reset
    repeat (3) @(posedge aclk);
    #1;
    chk("rst0_outs", {awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rresp, rlast, rdata}, '0);
    arst = 1'b0;
    @(posedge aclk); #1;
    chk("rst0_awready", 64'(awready), 64'd1);
    chk("rst0_arready", 64'(arready), 64'd1);

    // Reset during an active read burst (rready held low)
    arid = 4'hA; araddr = 32'h0; arlen = 8'd7; arburst = 2'b01; arvalid = 1'b1;
    @(posedge aclk); #1;
    arvalid = 1'b0;
    chk("t1_active", 64'(rvalid), 64'd1);
    arst = 1'b1;
    @(posedge aclk); #1;
    chk("t1_outs_zero", {awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rresp, rlast, rdata}, '0);
    @(posedge aclk); #1;
    arst = 1'b0;
    @(posedge aclk); #1;
    chk("t1_awready", 64'(awready), 64'd1);
    chk("t1_arready", 64'(arready), 64'd1);
    chk("t1_rvalid", 64'(rvalid), 64'd0);

    // INCR write and read-back
    wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333; wd[3] = 32'h44444444;
    axi_write("t2_wr", 4'h5, 32'h10, 8'd3, 2'b01, 4'hF, 3, 0, 2'b00);
    axi_read("t2_rd", 4'h9, 32'h10, 8'd3, 2'b01, -1, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_data%0d", i), 64'(rd[i]), 64'(wd[i]));
      chk($sformatf("t2_rresp%0d", i), 64'(rr[i]), 64'd0);
      chk($sformatf("t2_rlast%0d", i), 64'(rl[i]), 64'(i == 3));
    end

    // WRAP len 3 starting at 0x38: the beats land at 0x38, 0x3C, 0x30, 0x34
    wd[0] = 32'hA0A0A0A0; wd[1] = 32'hA1A1A1A1; wd[2] = 32'hA2A2A2A2; wd[3] = 32'hA3A3A3A3;
    axi_write("t3_wr", 4'h3, 32'h38, 8'd3, 2'b10, 4'hF, 3, 0, 2'b00);
    axi_read("t3_rinc", 4'h1, 32'h30, 8'd3, 2'b01, -1, 0);
    exp_w[0] = 32'hA2A2A2A2; exp_w[1] = 32'hA3A3A3A3; exp_w[2] = 32'hA0A0A0A0; exp_w[3] = 32'hA1A1A1A1;
    for (int i = 0; i < 4; i++) chk($sformatf("t3_inc%0d", i), 64'(rd[i]), 64'(exp_w[i]));
    axi_read("t3_rwrap", 4'h2, 32'h38, 8'd3, 2'b10, -1, 0);
    exp_w[0] = 32'hA0A0A0A0; exp_w[1] = 32'hA1A1A1A1; exp_w[2] = 32'hA2A2A2A2; exp_w[3] = 32'hA3A3A3A3;
    for (int i = 0; i < 4; i++) chk($sformatf("t3_wrap%0d", i), 64'(rd[i]), 64'(exp_w[i]));

    // Byte strobes applied to a word preloaded with zero
    wd[0] = 32'h0;
    axi_write("t4_pre", 4'h4, 32'h40, 8'd0, 2'b01, 4'hF, 0, 0, 2'b00);
    wd[0] = 32'hFFFFFFFF;
    axi_write("t4_strb", 4'h4, 32'h40, 8'd0, 2'b01, 4'b0101, 0, 0, 2'b00);
    axi_read("t4_rd", 4'h4, 32'h40, 8'd0, 2'b01, -1, 0);
    chk("t4_strb_data", 64'(rd[0]), 64'h00FF00FF);

    // wlast arrives early, on beat 2 of 4: SLVERR, but all 4 beats are still written
    wd[0] = 32'h50000000; wd[1] = 32'h50000001; wd[2] = 32'h50000002; wd[3] = 32'h50000003;
    axi_write("t4_early", 4'h6, 32'h50, 8'd3, 2'b01, 4'hF, 1, 0, 2'b10);
    axi_read("t4_early_rd", 4'h6, 32'h50, 8'd3, 2'b01, -1, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("t4_early_d%0d", i), 64'(rd[i]), 64'(wd[i]));

    // wlast never asserted: SLVERR
    wd[0] = 32'h80000000; wd[1] = 32'h80000001;
    axi_write("t4_nolast", 4'h7, 32'h80, 8'd1, 2'b01, 4'hF, 99, 0, 2'b10);

    // Reserved burst type: behaves as INCR, responds SLVERR
    wd[0] = 32'h600D0001; wd[1] = 32'h600D0002;
    axi_write("t4_rsv", 4'h8, 32'h60, 8'd1, 2'b11, 4'hF, 1, 0, 2'b10);
    axi_read("t4_rsv_rd", 4'h8, 32'h60, 8'd1, 2'b11, -1, 0);
    chk("t4_rsv_d0", 64'(rd[0]), 64'h600D0001);
    chk("t4_rsv_d1", 64'(rd[1]), 64'h600D0002);
    chk("t4_rsv_r0", 64'(rr[0]), 64'd2);
    chk("t4_rsv_r1", 64'(rr[1]), 64'd2);

    // FIXED: every beat goes to the same word, so the last beat wins
    wd[0] = 32'h1; wd[1] = 32'h2; wd[2] = 32'h3;
    axi_write("t4_fix", 4'hB, 32'h70, 8'd2, 2'b00, 4'hF, 2, 0, 2'b00);
    axi_read("t4_fix_rd", 4'hB, 32'h70, 8'd1, 2'b00, -1, 0);
    chk("t4_fix_d0", 64'(rd[0]), 64'h3);
    chk("t4_fix_d1", 64'(rd[1]), 64'h3);

    // Backpressure on R (3-cycle stall) and on B (5-cycle hold)
    axi_read("t5_rstall", 4'hC, 32'h10, 8'd3, 2'b01, 1, 3);
    chk("t5_stall_d1", 64'(rd[1]), 64'h22222222);
    chk("t5_stall_d3", 64'(rd[3]), 64'h44444444);
    wd[0] = 32'h90909090;
    axi_write("t5_bhold", 4'hD, 32'h90, 8'd0, 2'b01, 4'hF, 0, 5, 2'b00);

    // Out-of-range address
    wd[0] = 32'hCAFEF00D;
    axi_write("t6_w0", 4'hE, 32'h0, 8'd0, 2'b01, 4'hF, 0, 0, 2'b00);
    axi_read("t6_oor", 4'hE, 32'h1000, 8'd0, 2'b01, -1, 0);
`ifdef AXI_SLV_RANGE_CHECK_EN
    chk("t6_oor_data", 64'(rd[0]), 64'h0);
    chk("t6_oor_resp", 64'(rr[0]), 64'd3);
`else
    chk("t6_oor_data", 64'(rd[0]), 64'hCAFEF00D);
    chk("t6_oor_resp", 64'(rr[0]), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
